// File: rtl/crc_share_sched.sv
// crc_share_sched: one bit-serial CRC-8 / CRC-5 engine shared by two requesters.
// Round-robin arbitration with a valid/ready handshake, MSB-first serial
// division, then a single-cycle result strobe. Mode 0 appends the CRC to the
// data; mode 1 checks the trailing CRC and reports all zeros (pass) or all
// ones (fail).
module crc_share_sched #(
  parameter int         MSG_W     = 60,
  parameter logic [8:0] CRC8_POLY = 9'h131,
  parameter logic [5:0] CRC5_POLY = 6'h2B
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_mode,
  input  logic             req0_crc,
  input  logic [MSG_W-1:0] req0_msg,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_mode,
  input  logic             req1_crc,
  input  logic [MSG_W-1:0] req1_msg,
  output logic             out_valid,
  output logic             out_id,
  output logic [MSG_W-1:0] out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit index of the first (most significant) data bit for each CRC width.
  localparam logic [5:0] CNT_START8 = 6'd51;
  localparam logic [5:0] CNT_START5 = 6'd54;

  state_t             state;
  state_t             state_next;
  logic               last_grant;
  logic               mode_q;
  logic               crc_q;
  logic               id_q;
  logic [MSG_W-1:0]   data_q;
  logic [7:0]         chk_q;
  logic [7:0]         rem;
  logic [7:0]         rem_next;
  logic [5:0]         cnt;

  logic               grant0;
  logic               grant1;
  logic               accept;
  logic               sel_mode;
  logic               sel_crc;
  logic [MSG_W-1:0]   sel_msg;
  logic [MSG_W-1:0]   sel_data;
  logic               data_bit;
  logic               fb;
  logic               match;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign accept     = (state == IDLE) && (grant0 || grant1);
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;

  // Pick the winner's operands and right-align the data portion for check jobs.
  always_comb begin
    sel_mode = req0_mode;
    sel_crc  = req0_crc;
    sel_msg  = req0_msg;
    if (grant1) begin
      sel_mode = req1_mode;
      sel_crc  = req1_crc;
      sel_msg  = req1_msg;
    end
    sel_data = sel_msg;
    if (sel_mode) begin
      sel_data = sel_crc ? (sel_msg >> 5) : (sel_msg >> 8);
    end
  end

  // One step of the MSB-first serial division for the selected polynomial.
  always_comb begin
    data_bit = data_q[cnt];
    fb       = 1'b0;
    rem_next = rem;
    if (crc_q) begin
      fb       = rem[4] ^ data_bit;
      rem_next = {3'b000, {rem[3:0], 1'b0} ^ (fb ? CRC5_POLY[4:0] : 5'h00)};
    end else begin
      fb       = rem[7] ^ data_bit;
      rem_next = {rem[6:0], 1'b0} ^ (fb ? CRC8_POLY[7:0] : 8'h00);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: accept in IDLE, shift until bit 0 is consumed, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 6'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Job registers: capture operands at the accept edge, then run the division.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      mode_q     <= 1'b0;
      crc_q      <= 1'b0;
      id_q       <= 1'b0;
      data_q     <= '0;
      chk_q      <= 8'h00;
      rem        <= 8'h00;
      cnt        <= 6'd0;
    end else if (accept) begin
      last_grant <= grant1;
      mode_q     <= sel_mode;
      crc_q      <= sel_crc;
      id_q       <= grant1;
      data_q     <= sel_data;
      chk_q      <= sel_msg[7:0];
      rem        <= 8'h00;
      cnt        <= sel_crc ? CNT_START5 : CNT_START8;
    end else if (state == SHIFT) begin
      rem <= rem_next;
      if (cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
      end
    end
  end

  // Result formatting: appended CRC for generate, pass/fail pattern for check.
  always_comb begin
    match     = crc_q ? (rem[4:0] == chk_q[4:0]) : (rem == chk_q);
    out_valid = (state == DONE);
    out_id    = 1'b0;
    out       = '0;
    if (out_valid) begin
      out_id = id_q;
      if (!mode_q) begin
        out = crc_q ? {data_q[54:0], rem[4:0]} : {data_q[51:0], rem};
      end else begin
        out = match ? '0 : '1;
      end
    end
  end

endmodule
